// File: rtl/irrigation_sequencer.sv
// Irrigation scheduler: periodic sensor sample, one fuzzy evaluation per sample, then a
// tick-timed pump run. Rain aborts watering, keypad updates are granted only while idle.
module irrigation_sequencer #(
    parameter int SAMPLE_PERIOD = 1000,
    parameter int TIME_W        = 10,
    parameter int MAX_RUN       = 600,
    parameter int FUZZY_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              adc_valid,
    input  logic              fuzzy_done,
    input  logic [TIME_W-1:0] irrigation_time,
    input  logic              rain_present,
    input  logic              tick,
    input  logic              param_update_req,
    output logic              sensor_enable,
    output logic              fuzzy_start,
    output logic              pump_on,
    output logic              watering_in_progress,
    output logic [TIME_W-1:0] watering_timer,
    output logic              param_update_ack,
    output logic              fault,
    output logic [2:0]        state_dbg
);

    localparam int PERIOD_W  = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int TIMEOUT_W = $clog2(FUZZY_TIMEOUT + 1);

    localparam logic [PERIOD_W-1:0]  PERIOD_LAST  = PERIOD_W'(SAMPLE_PERIOD - 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(FUZZY_TIMEOUT - 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_MAX  = TIMEOUT_W'(FUZZY_TIMEOUT);
    localparam logic [TIME_W-1:0]    RUN_LIMIT    = TIME_W'(MAX_RUN);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SAMPLE = 3'd1,
        EVAL   = 3'd2,
        WATER  = 3'd3,
        FAULT  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [PERIOD_W-1:0]  period_cnt_q, period_cnt_d;
    logic [TIMEOUT_W-1:0] timeout_cnt_q, timeout_cnt_d;
    logic [TIME_W-1:0]    watering_timer_q, watering_timer_d;
    logic                 param_update_ack_q, param_update_ack_d;
    logic                 fuzzy_start_q, fuzzy_start_d;
    logic                 sensor_enable_q, sensor_enable_d;
    logic                 pump_on_q, pump_on_d;
    logic                 fault_q, fault_d;
    logic [TIME_W-1:0]    run_time;

    assign run_time = (irrigation_time > RUN_LIMIT) ? RUN_LIMIT : irrigation_time;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d            = state_q;
        period_cnt_d       = period_cnt_q;
        timeout_cnt_d      = timeout_cnt_q;
        watering_timer_d   = watering_timer_q;
        param_update_ack_d = 1'b0;
        fuzzy_start_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                param_update_ack_d = param_update_req;
                // A pending or active grant freezes the period and defers SAMPLE.
                if (!param_update_ack_q) begin
                    if (period_cnt_q != PERIOD_LAST) begin
                        period_cnt_d = period_cnt_q + 1'b1;
                    end else if (!param_update_req) begin
                        state_d      = SAMPLE;
                        period_cnt_d = '0;
                    end
                end
            end
            SAMPLE: begin
                if (adc_valid) begin
                    state_d       = EVAL;
                    fuzzy_start_d = 1'b1;
                    timeout_cnt_d = '0;
                end
            end
            EVAL: begin
                if (fuzzy_done) begin
                    timeout_cnt_d = '0;
                    if (run_time == '0 || rain_present) begin
                        state_d = IDLE;
                    end else begin
                        state_d          = WATER;
                        watering_timer_d = run_time;
                    end
                end else if (timeout_cnt_q == TIMEOUT_LAST) begin
                    state_d       = FAULT;
                    timeout_cnt_d = TIMEOUT_MAX;
                end else begin
                    timeout_cnt_d = timeout_cnt_q + 1'b1;
                end
            end
            WATER: begin
                if (rain_present) begin
                    state_d          = IDLE;
                    watering_timer_d = '0;
                end else if (tick && watering_timer_q != '0) begin
                    watering_timer_d = watering_timer_q - 1'b1;
                    if (watering_timer_q == TIME_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        sensor_enable_d = (state_d == SAMPLE);
        pump_on_d       = (state_d == WATER);
        fault_d         = (state_d == FAULT);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (reset) begin
            state_q            <= IDLE;
            period_cnt_q       <= '0;
            timeout_cnt_q      <= '0;
            watering_timer_q   <= '0;
            param_update_ack_q <= 1'b0;
            fuzzy_start_q      <= 1'b0;
            sensor_enable_q    <= 1'b0;
            pump_on_q          <= 1'b0;
            fault_q            <= 1'b0;
        end else begin
            state_q            <= state_d;
            period_cnt_q       <= period_cnt_d;
            timeout_cnt_q      <= timeout_cnt_d;
            watering_timer_q   <= watering_timer_d;
            param_update_ack_q <= param_update_ack_d;
            fuzzy_start_q      <= fuzzy_start_d;
            sensor_enable_q    <= sensor_enable_d;
            pump_on_q          <= pump_on_d;
            fault_q            <= fault_d;
        end
    end

    assign sensor_enable        = sensor_enable_q;
    assign fuzzy_start          = fuzzy_start_q;
    assign pump_on              = pump_on_q;
    assign watering_in_progress = pump_on_q;
    assign watering_timer       = watering_timer_q;
    assign param_update_ack     = param_update_ack_q;
    assign fault                = fault_q;
    assign state_dbg            = state_q;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Bench for irrigation_sequencer: directed vector table, hand-written corner sequences,
// and a randomized run against a cycle-level behavioural model.
module tb_irrigation_sequencer;

    localparam int SAMPLE_PERIOD = 8;
    localparam int TIME_W        = 10;
    localparam int MAX_RUN       = 600;
    localparam int FUZZY_TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              adc_valid = 1'b0;
    logic              fuzzy_done = 1'b0;
    logic [TIME_W-1:0] irrigation_time = '0;
    logic              rain_present = 1'b0;
    logic              tick = 1'b0;
    logic              param_update_req = 1'b0;
    logic              sensor_enable;
    logic              fuzzy_start;
    logic              pump_on;
    logic              watering_in_progress;
    logic [TIME_W-1:0] watering_timer;
    logic              param_update_ack;
    logic              fault;
    logic [2:0]        state_dbg;

    always #5 clk = ~clk;

    irrigation_sequencer #(
        .SAMPLE_PERIOD(SAMPLE_PERIOD),
        .TIME_W       (TIME_W),
        .MAX_RUN      (MAX_RUN),
        .FUZZY_TIMEOUT(FUZZY_TIMEOUT)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .adc_valid           (adc_valid),
        .fuzzy_done          (fuzzy_done),
        .irrigation_time     (irrigation_time),
        .rain_present        (rain_present),
        .tick                (tick),
        .param_update_req    (param_update_req),
        .sensor_enable       (sensor_enable),
        .fuzzy_start         (fuzzy_start),
        .pump_on             (pump_on),
        .watering_in_progress(watering_in_progress),
        .watering_timer      (watering_timer),
        .param_update_ack    (param_update_ack),
        .fault               (fault),
        .state_dbg           (state_dbg)
    );

    typedef struct {
        int rst, adc, done, irr, rain, tck, req;
        int st, sens, start, pump, timer, ack, flt;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    // Behavioural model: phase code, idle/eval ages, remaining run time.
    int m_phase, m_idle_age, m_eval_age, m_left, m_ack, m_start;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %h expected %h (st,sens,start,pump,wip,timer,ack,fault)",
                     name, actual, expected);
        end
    endtask

    function automatic logic [31:0] pack(input int st, input int sens, input int start,
                                         input int pump, input int wip, input int tmr,
                                         input int ack, input int flt);
        return {13'd0, 3'(st), 1'(sens), 1'(start), 1'(pump), 1'(wip), TIME_W'(tmr), 1'(ack), 1'(flt)};
    endfunction

    function automatic logic [31:0] dut_word();
        return {13'd0, state_dbg, sensor_enable, fuzzy_start, pump_on, watering_in_progress,
                watering_timer, param_update_ack, fault};
    endfunction

    task automatic drive(input int rst, input int adc, input int done, input int irr,
                         input int rain, input int tck, input int req);
        reset            = (rst != 0);
        adc_valid        = (adc != 0);
        fuzzy_done       = (done != 0);
        irrigation_time  = TIME_W'(irr);
        rain_present     = (rain != 0);
        tick             = (tck != 0);
        param_update_req = (req != 0);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input int st, input int sens, input int start,
                              input int pump, input int tmr, input int ack, input int flt);
        check(name, dut_word(), pack(st, sens, start, pump, pump, tmr, ack, flt));
    endtask

    function automatic void add(input int rst, input int adc, input int done, input int irr,
                                input int rain, input int tck, input int req,
                                input int st, input int sens, input int start, input int pump,
                                input int timer, input int ack, input int flt);
        vec_t v;
        v.rst = rst; v.adc = adc; v.done = done; v.irr = irr; v.rain = rain; v.tck = tck;
        v.req = req; v.st = st; v.sens = sens; v.start = start; v.pump = pump;
        v.timer = timer; v.ack = ack; v.flt = flt;
        vecs.push_back(v);
    endfunction

    // Counter starts at 0 in IDLE; SAMPLE appears after SAMPLE_PERIOD edges.
    function automatic void add_idle_to_sample(input int noise);
        for (int i = 0; i < SAMPLE_PERIOD - 1; i++)
            add(0, noise, noise, 0, 0, noise, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    endfunction

    function automatic void build_table();
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add_idle_to_sample(1);
        add(0, 0, 1, 9, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 3, 0, 0, 0, 3, 0, 0, 1, 3, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 1, 2, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 1, 2, 0, 0);
        add(0, 1, 0, 0, 0, 1, 0, 3, 0, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add_idle_to_sample(0);
        add(0, 1, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 1023, 0, 0, 0, 3, 0, 0, 1, 600, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 1, 599, 0, 0);
        add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add_idle_to_sample(0);
        add(0, 1, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 5, 0, 0, 0, 3, 0, 0, 1, 5, 0, 0);
        add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add_idle_to_sample(0);
        add(0, 1, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add_idle_to_sample(0);
        add(0, 1, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add_idle_to_sample(0);
        add(0, 1, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 600, 0, 0, 0, 3, 0, 0, 1, 600, 0, 0);
    endfunction

    task automatic go_to_eval();
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < SAMPLE_PERIOD; i++) drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        expect_out("eval_entry", 2, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic model_step(input int rst, input int adc, input int done, input int irr,
                              input int rain, input int tck, input int req);
        int run;
        m_start = 0;
        if (rst != 0) begin
            m_phase = 0; m_idle_age = 0; m_eval_age = 0; m_left = 0; m_ack = 0;
            return;
        end
        case (m_phase)
            0: begin
                if (m_ack == 0) begin
                    if (m_idle_age < SAMPLE_PERIOD - 1) m_idle_age++;
                    else if (req == 0) begin
                        m_phase    = 1;
                        m_idle_age = 0;
                    end
                end
                m_ack = req;
            end
            1: if (adc != 0) begin
                m_phase = 2; m_start = 1; m_eval_age = 0;
            end
            2: begin
                m_eval_age++;
                if (done != 0) begin
                    run = (irr > MAX_RUN) ? MAX_RUN : irr;
                    if (run == 0 || rain != 0) m_phase = 0;
                    else begin
                        m_phase = 3; m_left = run;
                    end
                end else if (m_eval_age >= FUZZY_TIMEOUT) m_phase = 4;
            end
            3: begin
                if (rain != 0) begin
                    m_phase = 0; m_left = 0;
                end else if (tck != 0) begin
                    m_left--;
                    if (m_left == 0) m_phase = 0;
                end
            end
            default: ;
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r_rst, r_adc, r_done, r_irr, r_rain, r_tck, r_req, sel;

        build_table();
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].adc, vecs[i].done, vecs[i].irr, vecs[i].rain,
                  vecs[i].tck, vecs[i].req);
            check($sformatf("vec[%0d]", i), dut_word(),
                  pack(vecs[i].st, vecs[i].sens, vecs[i].start, vecs[i].pump, vecs[i].pump,
                       vecs[i].timer, vecs[i].ack, vecs[i].flt));
        end

        // Fuzzy timeout: 64 EVAL cycles without done, then sticky FAULT until reset.
        go_to_eval();
        for (int i = 0; i < FUZZY_TIMEOUT - 1; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            expect_out("eval_wait", 2, 0, 0, 0, 0, 0, 0);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        expect_out("timeout_fault", 4, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) begin
            drive(0, i % 2, 1, 5, 0, 1, 1);
            expect_out("fault_sticky", 4, 0, 0, 0, 0, 0, 1);
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        expect_out("fault_reset", 0, 0, 0, 0, 0, 0, 0);

        // fuzzy_done in the timeout cycle wins; then reset lands mid-WATER.
        go_to_eval();
        for (int i = 0; i < FUZZY_TIMEOUT - 1; i++) drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 4, 0, 0, 0);
        expect_out("done_at_timeout", 3, 0, 0, 1, 4, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 0);
        expect_out("reset_in_water", 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        expect_out("idle_after_reset", 0, 0, 0, 0, 0, 0, 0);

        // Keypad grant in IDLE holds off SAMPLE for 50 cycles.
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        expect_out("grant_rise", 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 50; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1);
            expect_out("grant_hold", 0, 0, 0, 0, 0, 1, 0);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        expect_out("grant_fall", 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < SAMPLE_PERIOD - 2; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            expect_out("grant_resume", 0, 0, 0, 0, 0, 0, 0);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        expect_out("grant_then_sample", 1, 1, 0, 0, 0, 0, 0);

        // Request in the expiry cycle defers SAMPLE until ack has fallen.
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < SAMPLE_PERIOD - 1; i++) drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        expect_out("expiry_grant", 0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        expect_out("expiry_ack_fall", 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        expect_out("expiry_sample", 1, 1, 0, 0, 0, 0, 0);

        // Request during WATER is ignored until the return to IDLE.
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 2, 0, 0, 0);
        expect_out("water_req_entry", 3, 0, 0, 1, 2, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 1);
        expect_out("water_req_ignored", 3, 0, 0, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 1);
        expect_out("water_end_no_ack", 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        expect_out("idle_grant", 0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        expect_out("idle_grant_fall", 0, 0, 0, 0, 0, 0, 0);

        // Randomized run against the behavioural model.
        r_req = 0;
        drive(1, 0, 0, 0, 0, 0, 0);
        model_step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            r_rst  = (($urandom_range(0, 999) == 0) ||
                      (m_phase == 4 && $urandom_range(0, 15) == 0)) ? 1 : 0;
            r_adc  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            r_done = ($urandom_range(0, 79) == 0) ? 1 : 0;
            r_rain = ($urandom_range(0, 29) == 0) ? 1 : 0;
            r_tck  = int'($urandom_range(0, 1));
            if ($urandom_range(0, 29) == 0) r_req = 1 - r_req;
            sel = int'($urandom_range(0, 9));
            if (sel <= 5)      r_irr = int'($urandom_range(0, 6));
            else if (sel <= 7) r_irr = int'($urandom_range(590, 610));
            else if (sel == 8) r_irr = 1023;
            else               r_irr = int'($urandom_range(0, 1023));
            drive(r_rst, r_adc, r_done, r_irr, r_rain, r_tck, r_req);
            model_step(r_rst, r_adc, r_done, r_irr, r_rain, r_tck, r_req);
            check($sformatf("random[%0d]", i), dut_word(),
                  pack(m_phase, m_phase == 1, m_start, m_phase == 3, m_phase == 3, m_left,
                       m_ack, m_phase == 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
